// File: rtl/iomem_timer_pkg.sv
// Shared definitions for the iomem timer: register offsets, bit positions,
// default base address, handshake states and the byte-lane merge helper.
package iomem_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0300_0000;

    // Word offsets inside the 16-byte register window (addr[3:2])
    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    // CTRL / STATUS bit positions
    localparam int CTRL_EN           = 0;
    localparam int CTRL_AUTO_RELOAD  = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int CTRL_PRESCALE_LSB = 16;
    localparam int STATUS_MATCH      = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

    // Replace only the byte lanes enabled by wstrb
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                 input logic [31:0] wdata,
                                                 input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/iomem_timer_if.sv
// SoC iomem bus: initiator drives valid/wstrb/addr/wdata, responder
// returns a one-cycle ready pulse with rdata.
interface iomem_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output valid, wstrb, addr, wdata, input ready, rdata);
    modport slave  (input valid, wstrb, addr, wdata, output ready, rdata);
endinterface

// File: rtl/iomem_timer_prescaler.sv
// Prescaler: counts 0..prescale while enabled and flags the terminal cycle.
module iomem_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre;

    // Held at zero while disabled or cleared, otherwise wraps at prescale
    always_ff @(posedge clk) begin
        if (reset || clear || !en) pre <= '0;
        else if (pre == prescale)  pre <= '0;
        else                       pre <= pre + 1'b1;
    end

    assign tick = en && (pre == prescale);

endmodule

// File: rtl/iomem_timer.sv
// Memory-mapped 32-bit timer/compare peripheral on the iomem bus.
// Prescaled counter, compare match with optional auto-reload, W1C status, level irq.
module iomem_timer
    import iomem_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
    parameter int          PRESCALE_W = 16
) (
    input  logic   clk,
    input  logic   reset,
    iomem_if.slave iomem,
    output logic   irq
);

    bus_state_e            state, state_d;
    logic                  ctrl_en, ctrl_reload, ctrl_irq_en;
    logic [PRESCALE_W-1:0] ctrl_prescale;
    logic [31:0]           count, compare;
    logic                  match;
    logic [31:0]           rdata_q;

    logic        sel, accept, wr, tick, hit;
    logic [1:0]  off;
    logic [31:0] ctrl_rd, reg_rd, ctrl_wr_val;

    assign sel    = iomem.valid && (iomem.addr[31:4] == BASE_ADDR[31:4]);
    assign off    = iomem.addr[3:2];
    assign accept = (state == ST_IDLE) && sel;
    assign wr     = accept && (iomem.wstrb != 4'b0000);
    assign hit    = tick && (count == compare);

    // Register read mux; unimplemented bits read as zero
    always_comb begin
        ctrl_rd = '0;
        ctrl_rd[CTRL_EN]          = ctrl_en;
        ctrl_rd[CTRL_AUTO_RELOAD] = ctrl_reload;
        ctrl_rd[CTRL_IRQ_EN]      = ctrl_irq_en;
        ctrl_rd[CTRL_PRESCALE_LSB +: PRESCALE_W] = ctrl_prescale;
        reg_rd = '0;
        case (off)
            OFF_CTRL:    reg_rd = ctrl_rd;
            OFF_COUNT:   reg_rd = count;
            OFF_COMPARE: reg_rd = compare;
            OFF_STATUS:  reg_rd[STATUS_MATCH] = match;
            default:     reg_rd = '0;
        endcase
        ctrl_wr_val = apply_wstrb(ctrl_rd, iomem.wdata, iomem.wstrb);
    end

    // Any CTRL or COUNT write restarts the prescale phase
    iomem_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
        .clk      (clk),
        .reset    (reset),
        .en       (ctrl_en),
        .clear    (wr && (off == OFF_CTRL || off == OFF_COUNT)),
        .prescale (ctrl_prescale),
        .tick     (tick)
    );

    // Handshake state register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_d;
    end

    // Handshake next state: accept in IDLE, always return from ACK
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE: if (sel) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs: both zero unless acknowledging, so they can be OR-ed
    always_comb begin
        iomem.ready = (state == ST_ACK);
        iomem.rdata = (state == ST_ACK) ? rdata_q : 32'h0;
    end

    // Capture read data at accept time (pre-write value); writes return zero
    always_ff @(posedge clk) begin
        if (reset)       rdata_q <= '0;
        else if (accept) rdata_q <= wr ? 32'h0 : reg_rd;
    end

    // CTRL and COMPARE software registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en       <= 1'b0;
            ctrl_reload   <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            ctrl_prescale <= '0;
            compare       <= '0;
        end else if (wr) begin
            if (off == OFF_CTRL) begin
                ctrl_en       <= ctrl_wr_val[CTRL_EN];
                ctrl_reload   <= ctrl_wr_val[CTRL_AUTO_RELOAD];
                ctrl_irq_en   <= ctrl_wr_val[CTRL_IRQ_EN];
                ctrl_prescale <= ctrl_wr_val[CTRL_PRESCALE_LSB +: PRESCALE_W];
            end
            if (off == OFF_COMPARE) compare <= apply_wstrb(compare, iomem.wdata, iomem.wstrb);
        end
    end

    // Counter: software write beats a tick; wraps silently at all-ones
    always_ff @(posedge clk) begin
        if (reset)                         count <= '0;
        else if (wr && off == OFF_COUNT)   count <= apply_wstrb(count, iomem.wdata, iomem.wstrb);
        else if (hit && ctrl_reload)       count <= '0;
        else if (tick)                     count <= count + 32'd1;
    end

    // MATCH flag: a new match beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (reset)    match <= 1'b0;
        else if (hit) match <= 1'b1;
        else if (wr && off == OFF_STATUS && iomem.wstrb[0] && iomem.wdata[STATUS_MATCH])
            match <= 1'b0;
    end

    assign irq = match & ctrl_irq_en;

endmodule
